expl_sweep_ctrl: RTL and testbench

//  Sequencer and self-checker for the expl_beh gate network (x = a'bc | abc', y = a | ab'c).
//  On start, drives all 8 {a,b,c} vectors (000..111) in ascending order.

---
 rtl/expl_sweep_ctrl.sv | 171 +++++++++++++++++
 tb/tb_expl_sweep_ctrl.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/expl_sweep_ctrl.sv
// rtl/expl_sweep_ctrl.sv - exhaustive 3-input sweep sequencer and self-checker for the expl_beh gate network
//
// Drives {a,b,c} through 000..111 in ascending order. Each vector is held for
// SETTLE_CYC clocks so the gate delays can settle. The controller then samples
// x/y for one cycle and compares them with the golden function:
//   x = a'bc | abc'
//   y = a | ab'c
// It reports a per-vector error map, a fail count, and pass/done.
//
// Ports
//   clk       in   1  rising-edge clock
//   rst       in   1  synchronous active-high reset (highest priority)
//   start     in   1  begin a sweep; only accepted in IDLE
//   abort     in   1  cancel the sweep; only honoured in SETTLE/SAMPLE
//   abc       out  3  drive to the network under test, abc[2]=a, abc[0]=c
//   x_in      in   1  network output x
//   y_in      in   1  network output y
//   busy      out  1  high while the sweep runs (SETTLE/SAMPLE)
//   done      out  1  one-cycle pulse when a sweep completes (not on abort)
//   pass      out  1  no failing vectors at completion; held until next start
//   fail_cnt  out  4  number of failing vectors, 0..8
//   err_vec   out  8  bit k set when vector k mismatched on x or y
module expl_sweep_ctrl #(
    parameter int SETTLE_CYC = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    output logic [2:0] abc,
    input  logic       x_in,
    input  logic       y_in,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] fail_cnt,
    output logic [7:0] err_vec
);

    // Settle counter terminal value. The counter runs 0..SETTLE_CYC-1, so a
    // vector spends SETTLE_CYC cycles in SETTLE and one cycle in SAMPLE.
    localparam logic [3:0] CNT_LAST = 4'(SETTLE_CYC - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    state_t     state, state_n;
    logic [3:0] cnt, cnt_n;
    logic [2:0] abc_n;
    logic       busy_n;
    logic       done_n;
    logic       pass_n;
    logic [3:0] fail_cnt_n;
    logic [7:0] err_vec_n;

    // Golden response for the vector currently on the bus.
    logic a_bit, b_bit, c_bit;
    logic exp_x, exp_y;
    logic mismatch;

    always_comb begin
        a_bit    = abc[2];
        b_bit    = abc[1];
        c_bit    = abc[0];
        exp_x    = (~a_bit & b_bit & c_bit) | (a_bit & b_bit & ~c_bit);
        exp_y    = a_bit | (a_bit & ~b_bit & c_bit);
        mismatch = (x_in != exp_x) || (y_in != exp_y);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            cnt      <= 4'd0;
            abc      <= 3'd0;
            busy     <= 1'b0;
            done     <= 1'b0;
            pass     <= 1'b0;
            fail_cnt <= 4'd0;
            err_vec  <= 8'd0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            abc      <= abc_n;
            busy     <= busy_n;
            done     <= done_n;
            pass     <= pass_n;
            fail_cnt <= fail_cnt_n;
            err_vec  <= err_vec_n;
        end
    end

    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        abc_n      = abc;
        busy_n     = busy;
        done_n     = 1'b0;
        pass_n     = pass;
        fail_cnt_n = fail_cnt;
        err_vec_n  = err_vec;

        case (state)
            ST_IDLE: begin
                busy_n = 1'b0;
                // Results of the previous sweep stay visible until a new one starts.
                if (start) begin
                    state_n    = ST_SETTLE;
                    cnt_n      = 4'd0;
                    abc_n      = 3'd0;
                    busy_n     = 1'b1;
                    pass_n     = 1'b0;
                    fail_cnt_n = 4'd0;
                    err_vec_n  = 8'd0;
                end
            end

            ST_SETTLE: begin
                if (abort) begin
                    state_n = ST_IDLE;
                    busy_n  = 1'b0;
                    pass_n  = 1'b0;
                end else if (cnt == CNT_LAST) begin
                    state_n = ST_SAMPLE;
                end else begin
                    cnt_n = cnt + 4'd1;
                end
            end

            ST_SAMPLE: begin
                // Abort takes precedence over the sample, including on the final
                // vector, so an aborted sweep never produces a done pulse.
                if (abort) begin
                    state_n = ST_IDLE;
                    busy_n  = 1'b0;
                    pass_n  = 1'b0;
                end else begin
                    if (mismatch) begin
                        err_vec_n  = err_vec | (8'd1 << abc);
                        fail_cnt_n = fail_cnt + 4'd1;
                    end
                    if (abc == 3'd7) begin
                        // abc does not wrap; it stays at 7 until the next start.
                        state_n = ST_DONE;
                        busy_n  = 1'b0;
                        done_n  = 1'b1;
                        pass_n  = (fail_cnt_n == 4'd0);
                    end else begin
                        state_n = ST_SETTLE;
                        abc_n   = abc + 3'd1;
                        cnt_n   = 4'd0;
                    end
                end
            end

            ST_DONE: begin
                state_n = ST_IDLE;
                busy_n  = 1'b0;
            end

            default: begin
                state_n = ST_IDLE;
                busy_n  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_expl_sweep_ctrl.sv
// tb/tb_expl_sweep_ctrl.sv - self-checking bench for expl_sweep_ctrl with a fault-injectable network model
module tb_expl_sweep_ctrl;

    localparam int S = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       abort;
    logic [2:0] abc;
    logic       x_in;
    logic       y_in;
    logic       busy;
    logic       done;
    logic       pass;
    logic [3:0] fail_cnt;
    logic [7:0] err_vec;

    int tests = 0;
    int fails = 0;

    // Truth tables of the golden network, bit k = output for vector k.
    logic [7:0] gx_tab = 8'h48;
    logic [7:0] gy_tab = 8'hF0;

    // Fault injection: per-vector output inversions and stuck-at-0 forces.
    logic [7:0] xflip = 8'h00;
    logic [7:0] yflip = 8'h00;
    logic       force_x0 = 1'b0;
    logic       force_y0 = 1'b0;

    always #5 clk = ~clk;

    expl_sweep_ctrl #(.SETTLE_CYC(S)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .abort    (abort),
        .abc      (abc),
        .x_in     (x_in),
        .y_in     (y_in),
        .busy     (busy),
        .done     (done),
        .pass     (pass),
        .fail_cnt (fail_cnt),
        .err_vec  (err_vec)
    );

    function automatic logic drv_x(input int k);
        if (force_x0) return 1'b0;
        return gx_tab[k] ^ xflip[k];
    endfunction

    function automatic logic drv_y(input int k);
        if (force_y0) return 1'b0;
        return gy_tab[k] ^ yflip[k];
    endfunction

    always_comb begin
        x_in = drv_x(int'(abc));
        y_in = drv_y(int'(abc));
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: which vectors the checker should flag, given the injected faults.
    function automatic logic [7:0] ref_err();
        logic [7:0] e;
        e = 8'h00;
        for (int k = 0; k < 8; k++)
            if (drv_x(k) != gx_tab[k] || drv_y(k) != gy_tab[k]) e[k] = 1'b1;
        return e;
    endfunction

    function automatic int popcnt(input logic [7:0] v);
        int n;
        n = 0;
        for (int k = 0; k < 8; k++) n += int'(v[k]);
        return n;
    endfunction

    // Full sweep. Optionally glitch start mid-sweep or assert abort alongside start.
    task automatic run_sweep(input string tag, input bit glitch_start, input bit abort_w_start);
        logic [7:0] e;
        e = ref_err();
        @(negedge clk); start = 1'b1; abort = abort_w_start;
        @(posedge clk);
        @(negedge clk); start = 1'b0; abort = 1'b0;
        chk({tag, " busy@start"}, 32'(busy), 32'd1);
        chk({tag, " clr err_vec"}, 32'(err_vec), 32'd0);
        chk({tag, " clr pass"}, 32'(pass), 32'd0);
        for (int k = 0; k < 8; k++) begin
            if (glitch_start && k == 3) begin
                @(negedge clk); start = 1'b1;
                @(posedge clk);
                @(negedge clk); start = 1'b0;
                repeat (S - 1) @(posedge clk);
            end else begin
                repeat (S) @(posedge clk);
            end
            @(negedge clk);
            chk($sformatf("%s abc k%0d", tag, k), 32'(abc), 32'(k));
            chk($sformatf("%s busy/done k%0d", tag, k), {30'd0, busy, done}, 32'd2);
            @(posedge clk);
        end
        @(negedge clk);
        chk({tag, " done"}, 32'(done), 32'd1);
        chk({tag, " busy end"}, 32'(busy), 32'd0);
        chk({tag, " err_vec"}, 32'(err_vec), 32'(e));
        chk({tag, " fail_cnt"}, 32'(fail_cnt), 32'(popcnt(e)));
        chk({tag, " pass"}, 32'(pass), 32'(e == 8'h00));
        chk({tag, " abc hold"}, 32'(abc), 32'd7);
        @(negedge clk);
        chk({tag, " done drop"}, 32'(done), 32'd0);
        chk({tag, " pass hold"}, 32'(pass), 32'(e == 8'h00));
        chk({tag, " err hold"}, 32'(err_vec), 32'(e));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] e;
        bit         seen;
        rst = 1'b1; start = 1'b0; abort = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("reset outs", {16'd0, abc, busy, done, pass, fail_cnt, err_vec}, 32'd0);

        // Clean network.
        run_sweep("clean", 1'b0, 1'b0);

        // Stuck-at-0 outputs.
        force_x0 = 1'b1;
        run_sweep("x0", 1'b0, 1'b0);
        chk("x0 map", 32'(err_vec), 32'h48);
        force_x0 = 1'b0; force_y0 = 1'b1;
        run_sweep("y0", 1'b0, 1'b0);
        chk("y0 map", 32'(err_vec), 32'hF0);
        force_x0 = 1'b1;
        run_sweep("xy0", 1'b0, 1'b0);
        chk("xy0 cnt", 32'(fail_cnt), 32'd5);
        force_x0 = 1'b0; force_y0 = 1'b0;

        // Random per-vector faults.
        for (int i = 0; i < 4; i++) begin
            xflip = 8'($urandom_range(0, 255));
            yflip = 8'($urandom_range(0, 255)) & 8'($urandom_range(0, 255));
            run_sweep($sformatf("rnd%0d", i), 1'b0, 1'b0);
        end

        // Start while busy is ignored; start with abort in IDLE still starts.
        xflip = 8'h21; yflip = 8'h00;
        run_sweep("glitch", 1'b1, 1'b0);
        run_sweep("abort+start", 1'b0, 1'b1);

        // Abort mid-sweep: vectors 0 and 1 have been sampled, abc is at 2.
        xflip = 8'h03; yflip = 8'h04;
        e = ref_err() & 8'h03;
        @(negedge clk); start = 1'b1;
        @(posedge clk);
        @(negedge clk); start = 1'b0;
        repeat (11) @(posedge clk);
        @(negedge clk); abort = 1'b1;
        @(posedge clk);
        @(negedge clk); abort = 1'b0;
        chk("abort busy", 32'(busy), 32'd0);
        chk("abort abc", 32'(abc), 32'd2);
        chk("abort err", 32'(err_vec), 32'(e));
        chk("abort cnt", 32'(fail_cnt), 32'(popcnt(e)));
        chk("abort pass", 32'(pass), 32'd0);
        seen = 1'b0;
        repeat (50) begin
            @(negedge clk);
            if (done || busy) seen = 1'b1;
        end
        chk("abort quiet", 32'(seen), 32'd0);

        // Abort on the sample edge of vector 7.
        xflip = 8'h00; yflip = 8'h00;
        @(negedge clk); start = 1'b1;
        @(posedge clk);
        @(negedge clk); start = 1'b0;
        repeat (39) @(posedge clk);
        @(negedge clk); abort = 1'b1;
        @(posedge clk);
        @(negedge clk); abort = 1'b0;
        chk("abort7 done", 32'(done), 32'd0);
        chk("abort7 busy", 32'(busy), 32'd0);
        chk("abort7 pass", 32'(pass), 32'd0);
        chk("abort7 abc", 32'(abc), 32'd7);
        @(negedge clk);
        chk("abort7 done2", 32'(done), 32'd0);

        // Reset mid-sweep clears everything; a fresh sweep then passes.
        xflip = 8'h0F;
        @(negedge clk); start = 1'b1;
        @(posedge clk);
        @(negedge clk); start = 1'b0;
        repeat (21) @(posedge clk);
        @(negedge clk);
        chk("pre-rst err", 32'(err_vec), 32'h0F);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk); rst = 1'b0;
        chk("midrst outs", {16'd0, abc, busy, done, pass, fail_cnt, err_vec}, 32'd0);
        xflip = 8'h00;
        run_sweep("post-rst", 1'b0, 1'b0);
        chk("post-rst pass", 32'(pass), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
